tour_cmd_sequencer: RTL and testbench
=====================================

Name: tour_cmd_sequencer

Overview:
- Bench-side and stand-alone stimulus block upstream of RemoteComm.
- Buffers a queue of 16-bit Knight commands (e.g. CAL_GYRO, 16'h47F1 move-south) and issues them one at a time over RemoteComm's snd_cmd/cmd_snt handshake.
- Waits for each response byte, checks it against the positive acknowledge 8'hA5, and halts on a NAK or timeout.
- Lets whole tours be scripted as a command list instead of hand-sequenced SendCmd/ChkPosAck calls.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2.
- TMO_CLKS, 24'd12_000_000, clocks allowed in any wait state before timeout.
- POS_ACK, 8'hA5, expected response byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- push  in  1  enqueue push_cmd this cycle
- push_cmd  in  16  command to enqueue
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- start  in  1  begin draining the queue, or resume after an error
- cmd  out  16  command to RemoteComm
- snd_cmd  out  1  one-cycle send strobe to RemoteComm
- cmd_snt  in  1  RemoteComm finished transmitting
- resp_rdy  in  1  response byte valid (pulse)
- resp  in  8  response byte
- busy  out  1  sequencer active
- done  out  1  one-cycle pulse: queue drained, all commands acked
- err  out  1  sticky error flag
- err_code  out  2  01 = NAK (bad resp), 10 = timeout; 00 otherwise
- ack_cnt  out  8  count of positively acked commands; wraps at 255->0

Behaviour:
- Reset (async, rst=1): FIFO pointers=0, state=IDLE, cmd=0, snd_cmd=0, busy=0, done=0, err=0, err_code=0, ack_cnt=0, full=0, empty=1.
- FIFO:
  - Circular buffer; read/write pointers are log2(DEPTH)+1 bits, so the extra MSB distinguishes full from empty on wrap.
  - push while full is dropped; full is evaluated before the same-cycle pop.
  - push while empty with a same-cycle pop cannot occur, because pops only happen when non-empty.
  - push is legal in any state, including mid-tour.
- FSM states: IDLE, LOAD, SEND, WAIT_SNT, WAIT_RESP, ERR.
  - IDLE: on start && !empty -> LOAD. start with an empty queue is ignored.
  - LOAD: pop the head into cmd -> SEND.
  - SEND: snd_cmd=1 for exactly this cycle -> WAIT_SNT. cmd holds its value from LOAD until the next LOAD.
  - WAIT_SNT: on cmd_snt -> WAIT_RESP.
  - WAIT_RESP: on resp_rdy:
    - resp==POS_ACK: ack_cnt++, then !empty -> LOAD, or empty -> IDLE with done pulsed the same cycle as the transition.
    - Otherwise -> ERR with err_code=01.
  - Timeout: a counter clears on entry to WAIT_SNT and to WAIT_RESP and increments each cycle in those states. Reaching TMO_CLKS -> ERR with err_code=10. If resp_rdy or cmd_snt arrives in the same cycle the count expires, the event wins.
  - ERR: err=1 and err_code held. The failed command is discarded; the rest of the queue is retained.
    - On start: clear err/err_code, then !empty -> LOAD, else -> IDLE (no done pulse).
  - busy=1 in every state except IDLE and ERR.
- resp_rdy or cmd_snt arriving outside its wait state is ignored.
- Reset asserted mid-operation aborts immediately: queue flushed, snd_cmd forced 0 asynchronously.
- Latency: start -> snd_cmd is 2 cycles (LOAD, SEND). Final ack -> done is 1 cycle, registered.

Test Plan:
- Push CAL_GYRO then 16'h47F1, pulse start; model acks 8'hA5 for each -> exactly two snd_cmd pulses with matching cmd values, ack_cnt=2, one done pulse, busy=0, err=0.
- Push 9 commands with DEPTH=8 -> full=1 after the 8th; the 9th is dropped; draining yields exactly 8 sends in push order; empty=1 after the last pop (pointer wrap exercised by a second round of 8).
- Push 3 commands; the model replies 8'h5A to the 2nd -> err=1, err_code=01, ack_cnt=1. Pulse start -> the 3rd command is sent and acked, done pulses, err clears.
- Push 1 command; cmd_snt returns but resp_rdy never arrives (TMO_CLKS overridden to 100) -> ERR at exactly 100 cycles after WAIT_RESP entry, err_code=10, no done pulse.
- Assert rst while in WAIT_RESP with 4 commands still queued -> all outputs return to reset values immediately; a later start with no pushes produces no snd_cmd.
- resp_rdy pulsed while IDLE, and push during WAIT_RESP -> the stray response is ignored; the pushed command is sent after the current ack, with no gap state.

Source files
------------

// File: rtl/tour_cmd_sequencer.sv
// Command-queue sequencer that feeds 16-bit Knight commands to RemoteComm
// one at a time and halts on a NAK or a timeout.
module tour_cmd_sequencer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [23:0] TMO_CLKS = 24'd12_000_000,
  parameter logic [7:0]  POS_ACK  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_cmd,
  output logic        full,
  output logic        empty,
  input  logic        start,
  output logic [15:0] cmd,
  output logic        snd_cmd,
  input  logic        cmd_snt,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  ack_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [23:0] TMO_LAST = TMO_CLKS - 24'd1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_SNT,
    WAIT_RESP,
    ERR
  } state_t;

  state_t      state;
  logic [23:0] tmo_cnt;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [15:0] mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // The extra pointer MSB tells a wrapped (full) queue from an empty one.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = (state == LOAD);

  // NOTE: the storage array carries no reset; the pointers alone define which
  // entries are valid, so flushing the queue never needs to touch the array.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_cmd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch reads the pre-edge values of state, counters and queue flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      cmd      <= '0;
      snd_cmd  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      ack_cnt  <= '0;
    end else begin
      snd_cmd <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !empty) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          cmd     <= mem[rd_ptr[AW-1:0]];
          snd_cmd <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          tmo_cnt <= '0;
          state   <= WAIT_SNT;
        end
        WAIT_SNT: begin
          if (cmd_snt) begin
            tmo_cnt <= '0;
            state   <= WAIT_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b10;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        WAIT_RESP: begin
          // A response arriving on the expiry cycle still counts.
          if (resp_rdy) begin
            if (resp == POS_ACK) begin
              ack_cnt <= ack_cnt + 8'd1;
              if (empty) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= LOAD;
              end
            end else begin
              state    <= ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= 2'b01;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= ERR;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= 2'b10;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        ERR: begin
          if (start) begin
            err      <= 1'b0;
            err_code <= 2'b00;
            if (!empty) begin
              state <= LOAD;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Self-checking bench: scripted tours from a vector table, hand-built corner
// cases, then randomized tours checked against a queue-based reference model.
module tb_tour_cmd_sequencer;

  localparam int          DEPTH    = 8;
  localparam logic [15:0] CAL_GYRO = 16'h2000;
  localparam logic [7:0]  ACK      = 8'hA5;
  localparam int          NTBL     = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push = 1'b0;
  logic [15:0] push_cmd = '0;
  logic        start = 1'b0;
  logic        cmd_snt = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        full, empty, snd_cmd, busy, done, err;
  logic [15:0] cmd;
  logic [1:0]  err_code;
  logic [7:0]  ack_cnt;

  int vectors = 0;
  int miscompares = 0;
  int snd_seen = 0;
  int done_seen = 0;
  int acks = 0;
  logic [15:0] model_q[$];

  typedef struct {
    int         n;
    int         nak_idx;
    int         exp_acks;
    logic       exp_err;
    logic [1:0] exp_code;
    int         exp_dones;
    int         exp_sends;
  } vec_t;

  vec_t tbl[NTBL];

  tour_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .TMO_CLKS(24'd100),
    .POS_ACK (ACK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_cmd(push_cmd),
    .full    (full),
    .empty   (empty),
    .start   (start),
    .cmd     (cmd),
    .snd_cmd (snd_cmd),
    .cmd_snt (cmd_snt),
    .resp_rdy(resp_rdy),
    .resp    (resp),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_code(err_code),
    .ack_cnt (ack_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (snd_cmd) snd_seen++;
    if (done)    done_seen++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish (got running, required finished)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] c);
    push = 1'b1;
    push_cmd = c;
    tick();
    push = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(c);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_snd(output bit ok);
    logic [15:0] exp;
    ok = 1'b0;
    for (int t = 0; t < 40 && !snd_cmd; t++) tick();
    if (!snd_cmd) begin
      check("snd_cmd_wait", 0, 1);
      return;
    end
    if (model_q.size() == 0) begin
      check("unexpected_send", 1, 0);
      return;
    end
    exp = model_q.pop_front();
    check("cmd", cmd, exp);
    ok = 1'b1;
  endtask

  // Plays RemoteComm for one command: snt_dly must be >= 1 so cmd_snt lands in WAIT_SNT.
  task automatic serve(input logic [7:0] r, input int snt_dly, input int rsp_dly,
                       input bit do_push, input logic [15:0] pc, output bit ok);
    wait_snd(ok);
    if (!ok) return;
    repeat (snt_dly) tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (rsp_dly) tick();
    if (do_push) push_one(pc);
    resp_rdy = 1'b1;
    resp = r;
    tick();
    resp_rdy = 1'b0;
    if (r == ACK) acks++;
  endtask

  initial begin : main
    bit ok;
    int acks0, snd0, done0, rest;
    logic [7:0] r;

    tbl[0] = '{n:2, nak_idx:-1, exp_acks:2, exp_err:1'b0, exp_code:2'b00, exp_dones:1, exp_sends:2};
    tbl[1] = '{n:3, nak_idx:1,  exp_acks:1, exp_err:1'b1, exp_code:2'b01, exp_dones:0, exp_sends:2};
    tbl[2] = '{n:1, nak_idx:0,  exp_acks:0, exp_err:1'b1, exp_code:2'b01, exp_dones:0, exp_sends:1};
    tbl[3] = '{n:8, nak_idx:-1, exp_acks:8, exp_err:1'b0, exp_code:2'b00, exp_dones:1, exp_sends:8};
    tbl[4] = '{n:5, nak_idx:4,  exp_acks:4, exp_err:1'b1, exp_code:2'b01, exp_dones:0, exp_sends:5};

    #3;
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_busy", busy, 0);
    check("rst_snd_cmd", snd_cmd, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_ack_cnt", ack_cnt, 0);
    check("rst_cmd", cmd, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Scripted tours from the vector table, each NAK followed by a resume.
    for (int i = 0; i < NTBL; i++) begin
      acks0 = acks;
      snd0 = snd_seen;
      done0 = done_seen;
      for (int k = 0; k < tbl[i].n; k++)
        push_one(i == 0 ? (k == 0 ? CAL_GYRO : 16'h47F1) : 16'(16'h4000 + i * 16 + k));
      pulse_start();
      for (int k = 0; k < tbl[i].n; k++) begin
        serve((k == tbl[i].nak_idx) ? 8'h5A : ACK, 1 + k % 3, k % 2, 1'b0, 16'h0, ok);
        if (!ok || k == tbl[i].nak_idx) break;
      end
      tick();
      check("tbl_err", err, tbl[i].exp_err);
      check("tbl_err_code", err_code, tbl[i].exp_code);
      check("tbl_ack_cnt", ack_cnt, 32'((acks0 + tbl[i].exp_acks) % 256));
      check("tbl_done", done_seen - done0, tbl[i].exp_dones);
      check("tbl_sends", snd_seen - snd0, tbl[i].exp_sends);
      check("tbl_busy", busy, 0);
      if (tbl[i].exp_err) begin
        pulse_start();
        check("resume_err", err, 0);
        check("resume_err_code", err_code, 0);
        snd0 = snd_seen;
        done0 = done_seen;
        rest = model_q.size();
        while (model_q.size() > 0) begin
          serve(ACK, 2, 1, 1'b0, 16'h0, ok);
          if (!ok) break;
        end
        repeat (4) tick();
        check("resume_sends", snd_seen - snd0, rest);
        check("resume_done", done_seen - done0, rest > 0 ? 1 : 0);
        check("resume_ack_cnt", ack_cnt, 32'(acks % 256));
        check("resume_empty", empty, 1);
        check("resume_busy", busy, 0);
      end
    end

    // Fill past capacity twice; the second round wraps the pointers again.
    for (int round = 0; round < 2; round++) begin
      snd0 = snd_seen;
      done0 = done_seen;
      for (int k = 0; k < 9; k++) begin
        push_one(16'(16'h8000 + round * 16 + k));
        if (k == 6) check("full_at_7", full, 0);
        if (k == 7) check("full_at_8", full, 1);
      end
      check("full_after_9th", full, 1);
      pulse_start();
      while (model_q.size() > 0) begin
        serve(ACK, 1, 0, 1'b0, 16'h0, ok);
        if (!ok) break;
      end
      tick();
      check("drain_sends", snd_seen - snd0, 8);
      check("drain_done", done_seen - done0, 1);
      check("drain_empty", empty, 1);
      check("drain_full", full, 0);
      check("drain_ack_cnt", ack_cnt, 32'(acks % 256));
    end

    // Response timeout: ERR exactly 100 cycles after entering WAIT_RESP.
    done0 = done_seen;
    push_one(16'h1234);
    pulse_start();
    wait_snd(ok);
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    repeat (99) tick();
    check("tmo_err_at_99", err, 0);
    check("tmo_busy_at_99", busy, 1);
    tick();
    check("tmo_err_at_100", err, 1);
    check("tmo_err_code", err_code, 2'b10);
    check("tmo_busy", busy, 0);
    check("tmo_no_done", done_seen - done0, 0);
    pulse_start();
    check("tmo_resume_err", err, 0);
    check("tmo_resume_busy", busy, 0);

    // Reset in WAIT_RESP with four commands still queued.
    for (int k = 0; k < 5; k++) push_one(16'(16'h9000 + k));
    pulse_start();
    wait_snd(ok);
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    check("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_snd_cmd", snd_cmd, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_ack_cnt", ack_cnt, 0);
    check("arst_err", err, 0);
    check("arst_cmd", cmd, 0);
    model_q.delete();
    acks = 0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    snd0 = snd_seen;
    pulse_start();
    repeat (6) tick();
    check("post_rst_no_send", snd_seen - snd0, 0);
    check("post_rst_busy", busy, 0);

    // Stray handshakes while IDLE are ignored.
    snd0 = snd_seen;
    done0 = done_seen;
    resp_rdy = 1'b1;
    resp = ACK;
    cmd_snt = 1'b1;
    tick();
    resp_rdy = 1'b0;
    cmd_snt = 1'b0;
    tick();
    check("stray_ack_cnt", ack_cnt, 32'(acks % 256));
    check("stray_busy", busy, 0);
    check("stray_done", done_seen - done0, 0);

    // Push during WAIT_RESP: next command follows the ack with no idle gap.
    push_one(16'hC001);
    pulse_start();
    serve(ACK, 1, 1, 1'b1, 16'hBEEF, ok);
    check("midpush_busy", busy, 1);
    check("midpush_done", done, 0);
    tick();
    check("midpush_snd_cmd", snd_cmd, 1);
    check("midpush_cmd", cmd, 16'hBEEF);
    serve(ACK, 1, 0, 1'b0, 16'h0, ok);
    check("midpush_final_done", done, 1);
    check("midpush_ack_cnt", ack_cnt, 32'(acks % 256));

    // Randomized tours against the queue model.
    for (int tour = 0; tour < 30; tour++) begin
      rest = $urandom_range(1, 6);
      for (int k = 0; k < rest; k++) push_one(16'($urandom));
      pulse_start();
      while (model_q.size() > 0) begin
        r = 8'($urandom);
        if ($urandom_range(0, 7) != 0) r = ACK;
        else if (r == ACK) r = 8'h00;
        serve(r, $urandom_range(1, 4), $urandom_range(0, 4), $urandom_range(0, 3) == 0,
              16'($urandom), ok);
        if (!ok) break;
        if (r == ACK) begin
          check("rnd_ack_cnt", ack_cnt, 32'(acks % 256));
          check("rnd_done", done, model_q.size() == 0 ? 1 : 0);
          check("rnd_err", err, 0);
        end else begin
          check("rnd_nak_err", err, 1);
          check("rnd_nak_code", err_code, 2'b01);
          check("rnd_nak_done", done, 0);
          pulse_start();
          check("rnd_resume_err", err, 0);
        end
      end
      tick();
      check("rnd_idle_busy", busy, 0);
      check("rnd_idle_empty", empty, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
